// File: rtl/mod_mult_serial_if.sv
// Operand/result handshake bundle for the serial modular multiplier.
// Signal names keep the block's port naming, seen from the multiplier.
interface mod_mult_serial_if #(
  parameter int BITWIDTH = 16
);
  logic                iValid;
  logic                oReady;
  logic [BITWIDTH-1:0] iA;
  logic [BITWIDTH-1:0] iB;
  logic [BITWIDTH-1:0] iQ;
  logic                oValid;
  logic                iReady;
  logic [BITWIDTH-1:0] oData;

  modport master (
    output iValid, iA, iB, iQ, iReady,
    input  oReady, oValid, oData
  );

  modport slave (
    input  iValid, iA, iB, iQ, iReady,
    output oReady, oValid, oData
  );
endinterface

// File: rtl/mod_mult_serial.sv
// Bit-serial interleaved modular multiplier: oData = (A * B) mod Q, MSB-first
// double-and-add, one operand bit per cycle, one operation in flight.
module mod_mult_serial #(
  parameter int BITWIDTH = 16
) (
  input  logic               iClk,
  input  logic               iRstN,
  input  logic               iClr,
  mod_mult_serial_if.slave   bus
);

  localparam int CNT_W = (BITWIDTH > 1) ? $clog2(BITWIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              stateQ;
  state_t              stateD;
  logic [BITWIDTH-1:0] accQ;
  logic [BITWIDTH-1:0] aQ;
  logic [BITWIDTH-1:0] bQ;
  logic [BITWIDTH-1:0] qQ;
  logic [BITWIDTH-1:0] dataQ;
  logic [CNT_W-1:0]    cntQ;
  logic                validQ;

  logic [BITWIDTH-1:0] accNext;
  logic                accept;
  logic                lastStep;
  logic                resultTaken;

  // Single conditional subtract; valid because the operand is always < 2*m.
  function automatic logic [BITWIDTH:0] condSub(
    input logic [BITWIDTH:0] x,
    input logic [BITWIDTH:0] m
  );
    return (x < m) ? x : (x - m);
  endfunction

  // One double-and-add step, carried at BITWIDTH+1 bits so nothing overflows.
  function automatic logic [BITWIDTH-1:0] modStep(
    input logic [BITWIDTH-1:0] acc,
    input logic [BITWIDTH-1:0] a,
    input logic [BITWIDTH-1:0] q,
    input logic                b
  );
    logic [BITWIDTH:0] qExt;
    logic [BITWIDTH:0] dbl;
    logic [BITWIDTH:0] addend;
    logic [BITWIDTH:0] sum;
    qExt   = {1'b0, q};
    dbl    = condSub({acc, 1'b0}, qExt);
    addend = b ? {1'b0, a} : '0;
    sum    = condSub(dbl + addend, qExt);
    return sum[BITWIDTH-1:0];
  endfunction

  always_comb begin
    accNext = modStep(accQ, aQ, qQ, bQ[cntQ]);
  end

  always_comb begin
    stateD      = stateQ;
    accept      = 1'b0;
    lastStep    = 1'b0;
    resultTaken = 1'b0;
    unique case (stateQ)
      IDLE: begin
        if (bus.iValid) begin
          accept = 1'b1;
          stateD = CALC;
        end
      end
      CALC: begin
        if (cntQ == '0) begin
          lastStep = 1'b1;
          stateD   = DONE;
        end
      end
      DONE: begin
        if (bus.iReady) begin
          resultTaken = 1'b1;
          stateD      = IDLE;
        end
      end
      default: stateD = IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      stateQ <= IDLE;
    end else if (iClr) begin
      stateQ <= IDLE;
    end else begin
      stateQ <= stateD;
    end
  end

  // Operands are captured only on the accept edge; later bus changes are ignored.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      accQ   <= '0;
      aQ     <= '0;
      bQ     <= '0;
      qQ     <= '0;
      cntQ   <= '0;
      dataQ  <= '0;
      validQ <= 1'b0;
    end else if (iClr) begin
      accQ   <= '0;
      aQ     <= '0;
      bQ     <= '0;
      qQ     <= '0;
      cntQ   <= '0;
      dataQ  <= '0;
      validQ <= 1'b0;
    end else begin
      if (accept) begin
        aQ   <= bus.iA;
        bQ   <= bus.iB;
        qQ   <= bus.iQ;
        accQ <= '0;
        cntQ <= CNT_W'(BITWIDTH - 1);
      end
      if (stateQ == CALC) begin
        accQ <= accNext;
        if (!lastStep) begin
          cntQ <= cntQ - CNT_W'(1);
        end
      end
      if (lastStep) begin
        dataQ  <= accNext;
        validQ <= 1'b1;
      end
      if (resultTaken) begin
        validQ <= 1'b0;
      end
    end
  end

  assign bus.oReady = (stateQ == IDLE);
  assign bus.oValid = validQ;
  assign bus.oData  = dataQ;

endmodule

// File: tb/tb_mod_mult_serial.sv
// Directed and random checks of mod_mult_serial against a transaction-level
// model: result (A*B)%Q appears BITWIDTH cycles after accept and holds until taken.
module tb_mod_mult_serial;

  localparam int W = 16;

  logic iClk  = 1'b0;
  logic iRstN = 1'b0;
  logic iClr  = 1'b0;
  logic cmpEn = 1'b0;

  int checks = 0;
  int errors = 0;

  mod_mult_serial_if #(.BITWIDTH(W)) bus ();

  mod_mult_serial #(.BITWIDTH(W)) dut (
    .iClk  (iClk),
    .iRstN (iRstN),
    .iClr  (iClr),
    .bus   (bus)
  );

  always #5 iClk = ~iClk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: 0 idle, 1 computing, 2 result held
  int           mState;
  int           mLeft;
  logic [W-1:0] mRes;
  logic [W-1:0] mData;

  always @(posedge iClk or negedge iRstN) begin
    if (!iRstN || iClr) begin
      mState <= 0;
      mLeft  <= 0;
      mRes   <= '0;
      mData  <= '0;
    end else begin
      case (mState)
        0: if (bus.iValid) begin
          mRes   <= W'((64'(bus.iA) * 64'(bus.iB)) % 64'(bus.iQ));
          mLeft  <= W;
          mState <= 1;
        end
        1: begin
          mLeft <= mLeft - 1;
          if (mLeft == 1) begin
            mState <= 2;
            mData  <= mRes;
          end
        end
        2: if (bus.iReady) mState <= 0;
        default: mState <= 0;
      endcase
    end
  end

  always @(negedge iClk) begin
    if (cmpEn) begin
      chk("cmpReady", longint'(bus.oReady), longint'(mState == 0));
      chk("cmpValid", longint'(bus.oValid), longint'(mState == 2));
      chk("cmpData",  longint'(bus.oData),  longint'(mData));
    end
  end

  // Called at a negedge; returns at a negedge with the result handed off if iReady=1.
  task automatic runOp(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] q,
                       input bit scr, output logic [W-1:0] res, output int lat);
    int n;
    n   = 0;
    res = '0;
    lat = -1;
    while (!bus.oReady && n < 100) begin
      @(negedge iClk);
      n++;
    end
    if (!bus.oReady) begin
      chk("acceptTimeout", 0, 1);
      return;
    end
    bus.iValid = 1'b1;
    bus.iA = a;
    bus.iB = b;
    bus.iQ = q;
    @(negedge iClk);
    bus.iValid = 1'b0;
    if (scr) begin
      bus.iA = 16'd6;
      bus.iB = 16'd6;
      bus.iQ = 16'd11;
    end
    lat = 0;
    while (!bus.oValid && lat < 100) begin
      @(negedge iClk);
      lat++;
    end
    if (!bus.oValid) begin
      chk("resultTimeout", 0, 1);
      return;
    end
    res = bus.oData;
    if (bus.iReady) @(negedge iClk);
  endtask

  task automatic waitValid();
    int n;
    n = 0;
    while (!bus.oValid && n < 100) begin
      @(negedge iClk);
      n++;
    end
    if (!bus.oValid) chk("validTimeout", 0, 1);
  endtask

  logic [W-1:0] r;
  logic [W-1:0] held;
  int           lat;

  initial begin
    bus.iValid = 1'b0;
    bus.iA     = '0;
    bus.iB     = '0;
    bus.iQ     = '0;
    bus.iReady = 1'b1;
    repeat (3) @(negedge iClk);
    chk("rstReady", bus.oReady, 1);
    chk("rstValid", bus.oValid, 0);
    chk("rstData",  bus.oData,  0);
    iRstN = 1'b1;
    cmpEn = 1'b1;
    @(negedge iClk);

    runOp(16'd3, 16'd5, 16'd7, 1'b0, r, lat);
    chk("lat", lat, 16);
    chk("q7", r, 1);
    runOp(16'd65520, 16'd65535, 16'd65521, 1'b0, r, lat);
    chk("bigQ", r, 65507);
    runOp(16'd12345, 16'd0, 16'd65521, 1'b0, r, lat);
    chk("bZero", r, 0);
    runOp(16'd0, 16'd12345, 16'd1, 1'b0, r, lat);
    chk("qOne", r, 0);

    // Backpressure: result must hold while new operands are offered
    bus.iReady = 1'b0;
    bus.iValid = 1'b1;
    bus.iA = 16'd3; bus.iB = 16'd5; bus.iQ = 16'd7;
    @(negedge iClk);
    bus.iValid = 1'b0;
    waitValid();
    held = bus.oData;
    chk("bpData", held, 1);
    for (int i = 0; i < 10; i++) begin
      bus.iValid = 1'b1;
      bus.iA = 16'd2; bus.iB = 16'd4; bus.iQ = 16'd5;
      @(negedge iClk);
      chk("bpValid", bus.oValid, 1);
      chk("bpHold",  bus.oData, held);
      chk("bpReady", bus.oReady, 0);
    end
    bus.iReady = 1'b1;
    @(negedge iClk);
    chk("bpIdle", bus.oReady, 1);
    @(negedge iClk);
    chk("bpAccepted", bus.oReady, 0);
    bus.iValid = 1'b0;
    waitValid();
    chk("bpNext", bus.oData, 3);
    @(negedge iClk);

    runOp(16'd3, 16'd5, 16'd7, 1'b1, r, lat);
    chk("midChange", r, 1);

    // Clear while cnt == 8
    bus.iValid = 1'b1;
    bus.iA = 16'd3; bus.iB = 16'd5; bus.iQ = 16'd7;
    @(negedge iClk);
    bus.iValid = 1'b0;
    repeat (7) @(negedge iClk);
    iClr = 1'b1;
    @(negedge iClk);
    iClr = 1'b0;
    chk("clrReady", bus.oReady, 1);
    chk("clrValid", bus.oValid, 0);
    chk("clrData",  bus.oData,  0);
    runOp(16'd2, 16'd4, 16'd5, 1'b0, r, lat);
    chk("afterClr", r, 3);

    // Asynchronous reset mid-computation
    bus.iValid = 1'b1;
    bus.iA = 16'd3; bus.iB = 16'd5; bus.iQ = 16'd7;
    @(negedge iClk);
    bus.iValid = 1'b0;
    repeat (5) @(negedge iClk);
    #2 iRstN = 1'b0;
    #1;
    chk("arCalcReady", bus.oReady, 1);
    chk("arCalcValid", bus.oValid, 0);
    chk("arCalcData",  bus.oData,  0);
    @(negedge iClk);
    iRstN = 1'b1;

    // Asynchronous reset while a result is held
    bus.iReady = 1'b0;
    bus.iValid = 1'b1;
    bus.iA = 16'd3; bus.iB = 16'd5; bus.iQ = 16'd7;
    @(negedge iClk);
    bus.iValid = 1'b0;
    waitValid();
    chk("doneData", bus.oData, 1);
    #2 iRstN = 1'b0;
    #1;
    chk("arDoneReady", bus.oReady, 1);
    chk("arDoneValid", bus.oValid, 0);
    chk("arDoneData",  bus.oData,  0);
    @(negedge iClk);
    iRstN = 1'b1;
    bus.iReady = 1'b1;
    @(negedge iClk);
    runOp(16'd2, 16'd4, 16'd5, 1'b0, r, lat);
    chk("afterRst", r, 3);

    // Back-to-back random operations
    for (int i = 0; i < 2000; i++) begin
      int unsigned q, a, b;
      q = $urandom_range(65535, 1);
      a = $urandom_range(q - 1, 0);
      b = $urandom_range(65535, 0);
      runOp(W'(a), W'(b), W'(q), 1'b0, r, lat);
      chk("rand", r, longint'((longint'(a) * longint'(b)) % longint'(q)));
    end

    cmpEn = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
